// File: rtl/fp_mem_sequencer_if.sv
// ============================================================================
// Module   : fp_mem_sequencer_if
// Brief    : Request, memory-beat and datapath-control bundle of the FP
//            two-beat load/store sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fp_mem_sequencer_if;
    logic        ld_req;
    logic        st_req;
    logic [31:0] base_addr;
    logic [4:0]  fd_addr;
    logic        mem_rdy;

    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic        dp_din_sel;
    logic        dp_y_sel;
    logic        dp_d_en;
    logic [4:0]  dp_d_addr;
    logic        dp_dout_sel;
    logic        busy;
    logic        done;
    logic        err;

    // Requester / memory / datapath environment side
    modport master (
        output ld_req, st_req, base_addr, fd_addr, mem_rdy,
        input  mem_addr, mem_rd, mem_wr, dp_din_sel, dp_y_sel, dp_d_en,
               dp_d_addr, dp_dout_sel, busy, done, err
    );

    // Sequencer side
    modport slave (
        input  ld_req, st_req, base_addr, fd_addr, mem_rdy,
        output mem_addr, mem_rd, mem_wr, dp_din_sel, dp_y_sel, dp_d_en,
               dp_d_addr, dp_dout_sel, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/fp_mem_sequencer.sv
// ============================================================================
// Module   : fp_mem_sequencer
// Brief    : Two-beat 64-bit load/store sequencer between a 32-bit memory
//            port and the FP datapath, with per-beat wait-state timeout.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_mem_sequencer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_mem_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_LO = 3'd1,
        LD_HI = 3'd2,
        LD_WB = 3'd3,
        ST_LO = 3'd4,
        ST_HI = 3'd5
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [31:0] base_q;
    logic [4:0]  fd_q;
    logic [15:0] wait_q, wait_d;
    logic        done_d, err_d;
    logic        beat_w, tmo_w;
    logic [31:0] base_w;
    logic [4:0]  fd_w;

    always_comb begin
        // In IDLE the request fields are live; afterwards use the latched copy.
        base_w  = (state_q == IDLE) ? bus.base_addr : base_q;
        fd_w    = (state_q == IDLE) ? bus.fd_addr   : fd_q;
        beat_w  = (state_q == LD_LO) || (state_q == LD_HI) ||
                  (state_q == ST_LO) || (state_q == ST_HI);
        tmo_w   = beat_w && !bus.mem_rdy && (wait_q == TMO_LAST);
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ld_req)      state_d = LD_LO;
                else if (bus.st_req) state_d = ST_LO;
            end
            LD_LO: begin
                if (bus.mem_rdy)     state_d = LD_HI;
                else if (tmo_w)      begin state_d = IDLE; err_d = 1'b1; end
            end
            LD_HI: begin
                if (bus.mem_rdy)     state_d = LD_WB;
                else if (tmo_w)      begin state_d = IDLE; err_d = 1'b1; end
            end
            LD_WB: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            ST_LO: begin
                if (bus.mem_rdy)     state_d = ST_HI;
                else if (tmo_w)      begin state_d = IDLE; err_d = 1'b1; end
            end
            ST_HI: begin
                if (bus.mem_rdy)     begin state_d = IDLE; done_d = 1'b1; end
                else if (tmo_w)      begin state_d = IDLE; err_d = 1'b1; end
            end
            default: state_d = IDLE;
        endcase
        // Staying inside a beat implies mem_rdy was low this cycle.
        wait_d = (beat_w && (state_d == state_q)) ? wait_q + 16'd1 : 16'd0;
    end

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            base_q          <= 32'd0;
            fd_q            <= 5'd0;
            wait_q          <= 16'd0;
            bus.mem_addr    <= 32'd0;
            bus.mem_rd      <= 1'b0;
            bus.mem_wr      <= 1'b0;
            bus.dp_din_sel  <= 1'b0;
            bus.dp_y_sel    <= 1'b0;
            bus.dp_d_en     <= 1'b0;
            bus.dp_d_addr   <= 5'd0;
            bus.dp_dout_sel <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_w;
            fd_q    <= fd_w;
            wait_q  <= wait_d;

            bus.mem_rd      <= (state_d == LD_LO) || (state_d == LD_HI);
            bus.mem_wr      <= (state_d == ST_LO) || (state_d == ST_HI);
            if ((state_d == LD_LO) || (state_d == ST_LO))
                bus.mem_addr <= base_w;
            else if ((state_d == LD_HI) || (state_d == ST_HI))
                bus.mem_addr <= base_w + 32'd4;
            else
                bus.mem_addr <= 32'd0;
            bus.dp_din_sel  <= (state_d == LD_HI) || (state_d == LD_WB);
            bus.dp_y_sel    <= (state_d == LD_WB);
            bus.dp_d_en     <= (state_d == LD_WB);
            bus.dp_d_addr   <= (state_d == LD_WB) ? fd_w : 5'd0;
            bus.dp_dout_sel <= (state_d == ST_HI);
            bus.busy        <= (state_d != IDLE);
            bus.done        <= done_d;
            bus.err         <= err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_mem_sequencer.sv
// ============================================================================
// Module   : tb_fp_mem_sequencer
// Brief    : Directed bench with a memory responder and Din/regfile model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_mem_sequencer;

    localparam int          TMO     = 4;
    localparam logic [63:0] RF_INIT = 64'hFEED_0000_FEED_0000;

    typedef struct {
        bit          is_ld;
        bit          both;
        bit          poke;
        logic [31:0] base;
        logic [31:0] hi_addr;
        logic [4:0]  fd;
        int          waits;
        logic [31:0] w_lo;
        logic [31:0] w_hi;
        logic [63:0] val;
        int          exp_cyc;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_mem_sequencer_if bus();

    fp_mem_sequencer #(.TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [logic [31:0]];
    logic [63:0] rf [32] = '{default: RF_INIT};
    logic [63:0] alu;
    logic [31:0] lo_buf, hi_buf;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wait_cfg;
    int          bcnt;
    int          n_pass  = 0;
    int          n_total = 0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hBAD0_BAD0;
    endfunction

    // Datapath stand-in: Din buffers, regfile and D_OUT write capture
    always @(posedge clk) begin
        if (bus.mem_rd && bus.mem_rdy) begin
            if (bus.dp_din_sel) hi_buf <= rd(bus.mem_addr);
            else                lo_buf <= rd(bus.mem_addr);
        end
        if (bus.dp_d_en && bus.dp_y_sel)
            rf[bus.dp_d_addr] <= {hi_buf, lo_buf};
        if (bus.mem_wr && bus.mem_rdy) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.dp_dout_sel ? alu[63:32] : alu[31:0]);
        end
    end

    // Memory responder: ready in beat cycle wait_cfg+1, never if wait_cfg<0
    always @(negedge clk) begin
        if (!(bus.mem_rd || bus.mem_wr)) begin
            bcnt        = 0;
            bus.mem_rdy = 1'b0;
        end else begin
            if (bus.mem_rdy) bcnt = 0;
            bus.mem_rdy = (wait_cfg >= 0) && (bcnt == wait_cfg);
            bcnt++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.mem_addr, bus.mem_rd, bus.mem_wr, bus.dp_din_sel, bus.dp_y_sel,
                    bus.dp_d_en, bus.dp_d_addr, bus.dp_dout_sel, bus.busy, bus.done, bus.err});
    endfunction

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic issue(input bit ld, input bit st, input logic [31:0] base, input logic [4:0] fd);
        bus.ld_req    = ld;
        bus.st_req    = st;
        bus.base_addr = base;
        bus.fd_addr   = fd;
        @(posedge clk);
        @(negedge clk);
        bus.ld_req = 1'b0;
        bus.st_req = 1'b0;
        bus.base_addr = 32'h5555_5555;
        bus.fd_addr   = 5'd31;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          cyc, done_cyc, rd_cnt, wr_cnt, n0;
        bit          err_seen;
        logic        busy1;
        logic [31:0] lo_seen, hi_seen;
        wait_cfg = v.waits;
        alu      = v.val;
        if (v.is_ld) begin
            mem[v.base]    = v.w_lo;
            mem[v.hi_addr] = v.w_hi;
        end
        n0 = wr_addr_q.size();
        issue(v.is_ld, !v.is_ld || v.both, v.base, v.fd);
        busy1 = bus.busy;
        cyc = 1; done_cyc = -1; rd_cnt = 0; wr_cnt = 0; err_seen = 0;
        lo_seen = 32'hX; hi_seen = 32'hX;
        while (cyc <= 40) begin
            if (bus.mem_rd) begin
                rd_cnt++;
                if (bus.dp_din_sel) hi_seen = bus.mem_addr;
                else                lo_seen = bus.mem_addr;
            end
            if (bus.mem_wr) wr_cnt++;
            if (bus.err) err_seen = 1;
            bus.ld_req = (v.poke && cyc == 2);
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        bus.ld_req = 1'b0;
        chk($sformatf("v%0d busy_c1", idx), 64'(busy1), 64'd1);
        chk($sformatf("v%0d done_cycle", idx), 64'(done_cyc), 64'(v.exp_cyc));
        chk($sformatf("v%0d no_err", idx), 64'(err_seen), 64'd0);
        if (v.is_ld) begin
            chk($sformatf("v%0d rf", idx), rf[v.fd], v.val);
            chk($sformatf("v%0d lo_addr", idx), 64'(lo_seen), 64'(v.base));
            chk($sformatf("v%0d hi_addr", idx), 64'(hi_seen), 64'(v.hi_addr));
            chk($sformatf("v%0d rd_cycles", idx), 64'(rd_cnt), 64'(2 * (v.waits + 1)));
            chk($sformatf("v%0d no_wr", idx), 64'(wr_cnt), 64'd0);
        end else begin
            chk($sformatf("v%0d wr_count", idx), 64'(wr_addr_q.size() - n0), 64'd2);
            if (wr_addr_q.size() >= n0 + 2) begin
                chk($sformatf("v%0d wr0_addr", idx), 64'(wr_addr_q[n0]),   64'(v.base));
                chk($sformatf("v%0d wr0_data", idx), 64'(wr_data_q[n0]),   64'(v.w_lo));
                chk($sformatf("v%0d wr1_addr", idx), 64'(wr_addr_q[n0+1]), 64'(v.hi_addr));
                chk($sformatf("v%0d wr1_data", idx), 64'(wr_data_q[n0+1]), 64'(v.w_hi));
            end
            chk($sformatf("v%0d no_rd", idx), 64'(rd_cnt), 64'd0);
        end
        @(negedge clk);
        chk($sformatf("v%0d idle_after", idx), 64'(bus.busy), 64'd0);
        chk($sformatf("v%0d done_pulse", idx), 64'(bus.done), 64'd0);
    endtask

    initial begin
        vec_t vecs[5];
        vec_t v;
        int   cyc, err_cyc;
        bit   seen;

        vecs[0] = '{1, 0, 0, 32'h0000_0100, 32'h0000_0104, 5'd7, 0,
                    32'h89AB_CDEF, 32'h0123_4567, 64'h0123_4567_89AB_CDEF, 4};
        vecs[1] = '{0, 0, 1, 32'h0000_0200, 32'h0000_0204, 5'd0, 2,
                    32'hCAFE_F00D, 32'hDEAD_BEEF, 64'hDEAD_BEEF_CAFE_F00D, 7};
        vecs[2] = '{1, 0, 0, 32'hFFFF_FFFC, 32'h0000_0000, 5'd3, 1,
                    32'h1111_2222, 32'h3333_4444, 64'h3333_4444_1111_2222, 6};
        vecs[3] = '{1, 1, 0, 32'h0000_0300, 32'h0000_0304, 5'd9, 3,
                    32'hAAAA_5555, 32'h5555_AAAA, 64'h5555_AAAA_AAAA_5555, 10};
        vecs[4] = '{0, 0, 0, 32'h0000_0010, 32'h0000_0014, 5'd0, 0,
                    32'h89AB_CDEF, 32'h0123_4567, 64'h0123_4567_89AB_CDEF, 3};

        bus.ld_req = 1'b0; bus.st_req = 1'b0;
        bus.base_addr = 32'd0; bus.fd_addr = 5'd0;
        wait_cfg = 0; alu = 64'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", outs(), 64'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Timeout: memory never ready on a load
        wait_cfg = -1;
        issue(1'b1, 1'b0, 32'h0000_0400, 5'd12);
        cyc = 1; err_cyc = -1; seen = 0;
        while (cyc <= 20) begin
            if (bus.done) seen = 1;
            if (bus.err) begin
                err_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk("tmo err_cycle", 64'(err_cyc), 64'd5);
        chk("tmo busy", 64'(bus.busy), 64'd0);
        chk("tmo no_done", 64'({seen, bus.done}), 64'd0);
        chk("tmo rf_kept", rf[12], RF_INIT);
        @(negedge clk);
        chk("tmo err_pulse", 64'(bus.err), 64'd0);

        // Async reset while the high beat is outstanding
        wait_cfg = 2;
        mem[32'h500] = 32'h7777_0000;
        mem[32'h504] = 32'h0000_7777;
        issue(1'b1, 1'b0, 32'h0000_0500, 5'd20);
        cyc = 1; seen = 0;
        while (cyc <= 20 && !(bus.mem_rd && bus.dp_din_sel)) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst reached_ld_hi", 64'(bus.mem_rd && bus.dp_din_sel), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst async_clear", outs(), 64'd0);
        repeat (2) begin
            @(negedge clk);
            if (bus.done || bus.err || bus.busy) seen = 1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.done || bus.err || bus.busy) seen = 1;
        end
        chk("rst no_activity", 64'(seen), 64'd0);
        chk("rst rf_kept", rf[20], RF_INIT);
        v    = vecs[0];
        v.fd = 5'd20;
        run_vec(v, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/fp_mem_sequencer.md
# fp_mem_sequencer

Two-beat load/store sequencer between the 32-bit data-memory port and the 64-bit floating-point datapath. On a load, it fetches the low and high words over two memory beats and steers them into the datapath's Din LO/HI buffers. It then commits the 64-bit pair to the FP register file. On a store, it drives the datapath's output half-select so the 64-bit ALU result leaves as two 32-bit memory writes. A bounded wait-state timeout aborts stalled transfers.

## Interface
Parameters:
- TIMEOUT_CYC, 255: maximum cycles per beat with mem_rdy low before the transfer aborts (1..65535).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- ld_req  in  1  start 64-bit load; sampled only in IDLE.
- st_req  in  1  start 64-bit store; sampled only in IDLE.
- base_addr  in  32  byte address of low word; captured at accept.
- fd_addr  in  5  FP destination register for a load; captured at accept.
- mem_rdy  in  1  memory beat complete; read data valid on datapath DY in this cycle.
- mem_addr  out  32  memory address.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe; memory write data is the datapath D_OUT.
- dp_din_sel  out  1  datapath DIN_Sel (0 = LO buffer loads, 1 = HI buffer loads).
- dp_y_sel  out  1  datapath Y_Sel (1 = regfile D input from Din buffers).
- dp_d_en  out  1  datapath regfile write enable.
- dp_d_addr  out  5  datapath regfile D address.
- dp_dout_sel  out  1  datapath DOut_Sel (0 = low half, 1 = high half).
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on timeout abort.

## Operation
- All outputs are registered, Moore-decoded from the state. On reset, every output is 0 and the state is IDLE.
- States are IDLE, LD_LO, LD_HI, LD_WB, ST_LO, ST_HI.
- IDLE:
  - ld_req=1 goes to LD_LO. Otherwise st_req=1 goes to ST_LO.
  - If ld_req and st_req are both 1, the load wins and the store is dropped.
  - base_addr and fd_addr are latched on accept.
- Requests while busy=1 are ignored and not queued.
- LD_LO: mem_rd=1, mem_addr=base, dp_din_sel=0. mem_rdy=1 goes to LD_HI.
- LD_HI: mem_rd=1, mem_addr=base+4, dp_din_sel=1. mem_rdy=1 goes to LD_WB.
- LD_WB: one cycle with dp_y_sel=1, dp_d_en=1, dp_d_addr=fd_addr, dp_din_sel=1. Then IDLE with done=1.
- ST_LO: mem_wr=1, mem_addr=base, dp_dout_sel=0. mem_rdy=1 goes to ST_HI.
- ST_HI: mem_wr=1, mem_addr=base+4, dp_dout_sel=1. mem_rdy=1 goes to IDLE with done=1.
- Address arithmetic: base+4 is 32-bit modulo, so 0xFFFF_FFFC+4 = 0x0000_0000.
- Strobes and address are held constant for the whole beat, including the mem_rdy cycle.
- Timeout:
  - A per-beat wait counter clears on entering each beat and increments on each beat cycle with mem_rdy=0.
  - If the TIMEOUT_CYC-th beat cycle still has mem_rdy=0, the next state is IDLE with err=1 and no regfile write.
  - mem_rdy=1 in the TIMEOUT_CYC-th cycle completes normally, so ready wins over timeout.
- Store precondition: upstream holds the ALU in pass-through of the source register from one cycle before st_req until done, so D_OUT is stable.
- busy=1 in every non-IDLE state. done and err are never both 1.

## Timing
- Load with zero-wait memory (accept edge = cycle 0):
  - LD_LO in cycle 1, LD_HI in cycle 2, LD_WB in cycle 3 (regfile written at the end of cycle 3).
  - done=1 in cycle 4. Total latency is 4 cycles.
- Store with zero-wait memory: ST_LO in cycle 1, ST_HI in cycle 2, done in cycle 3.
- Each memory wait cycle adds one cycle to the beat.
- A new request is accepted in the cycle done or err is high, because the block is already in IDLE.
- DIN buffers capture DY at the mem_rdy edge of their beat. The regfile samples buffer outputs at the LD_WB edge, so buffer reloads in LD_WB are harmless.
- Async reset mid-transfer clears everything immediately: no regfile write, no further strobes, no done/err pulse.

## Test plan
- Load, zero-wait: base=0x100, fd=7, memory returns 0x89AB_CDEF at 0x100 and 0x0123_4567 at 0x104 → f7=0x0123_4567_89AB_CDEF, done at cycle 4.
- Store with 2 wait states per beat: ALU passes 0xDEAD_BEEF_CAFE_F00D, base=0x200 → writes 0xCAFE_F00D@0x200, then 0xDEAD_BEEF@0x204, then done.
- Timeout with TIMEOUT_CYC=4, mem_rdy never asserted on a load → err at cycle 5, regfile unchanged, busy=0. Repeat with mem_rdy in beat cycle 4 → no err.
- ld_req and st_req together in IDLE → load performed, no mem_wr ever asserted. ld_req pulsed while busy → ignored.
- Wrap: base=0xFFFF_FFFC load → second beat at mem_addr=0x0000_0000.
- RESET low during LD_HI → all outputs 0 asynchronously, target register keeps its old value, and a subsequent load completes normally.
